gpio_seq_ctrl: RTL

//  Parametrised GPIO pattern sequencer and input matcher for the user project area. It drives

---
 rtl/gpio_seq_ctrl_if.sv | 43 ++++
 rtl/gpio_seq_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_seq_ctrl_if.sv
// GPIO sequencer bus bundle: pattern-memory config, run control, matcher setup and pad signals.
// Latency: none (wires only).
// Backpressure: none; all strobes are single-cycle pulses that are always accepted.
// Ports: master = register-file side (drives config/control, reads pads/status),
//        slave  = gpio_seq_ctrl.
interface gpio_seq_ctrl_if #(
  parameter int IO_WIDTH   = 38,
  parameter int DEPTH      = 16,
  parameter int PRESCALE_W = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic                  cfg_we;
  logic [AW-1:0]         cfg_addr;
  logic [IO_WIDTH-1:0]   cfg_wdata;
  logic                  start;
  logic                  stop;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] prescale;
  logic [AW-1:0]         last_idx;
  logic [IO_WIDTH-1:0]   out_en;
  logic [IO_WIDTH-1:0]   match_val;
  logic [IO_WIDTH-1:0]   match_mask;
  logic [IO_WIDTH-1:0]   io_in;
  logic [IO_WIDTH-1:0]   io_out;
  logic [IO_WIDTH-1:0]   io_oeb;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         step_idx;
  logic                  match_irq;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, stop, mode, prescale, last_idx,
           out_en, match_val, match_mask, io_in,
    input  io_out, io_oeb, busy, done, step_idx, match_irq
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, stop, mode, prescale, last_idx,
           out_en, match_val, match_mask, io_in,
    output io_out, io_oeb, busy, done, step_idx, match_irq
  );
endinterface

// File: rtl/gpio_seq_ctrl.sv
// GPIO pattern sequencer (one-shot/loop/counter/ping-pong) with masked input matcher.
// Latency: start -> first word on io_out 1 cycle; io_in change -> match_irq 3 cycles.
// Backpressure: none; start is ignored while running, stop wins over a simultaneous start.
// Ports: wb_clk_i/wb_rst_i (sync, active-high) plain; everything else via bus (slave modport):
//   cfg_we/cfg_addr/cfg_wdata write the pattern memory; start/stop/mode/prescale/last_idx run control;
//   out_en, match_val/match_mask, io_in inputs; io_out/io_oeb/busy/done/step_idx/match_irq registered outputs.
module gpio_seq_ctrl #(
  parameter int IO_WIDTH   = 38,
  parameter int DEPTH      = 16,
  parameter int PRESCALE_W = 16
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  gpio_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_COUNT    = 2'd2;
  localparam logic [1:0] MODE_PINGPONG = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  // Pattern memory: no reset, written any time. Reads are from the flop array,
  // so a load in the same cycle as a write to that entry sees the old word.
  logic [IO_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge wb_clk_i) begin
    if (bus.cfg_we) mem_q[bus.cfg_addr] <= bus.cfg_wdata;
  end

  state_e                state_q,     state_d;
  logic [1:0]            mode_q,      mode_d;
  logic [PRESCALE_W-1:0] prescale_q,  prescale_d;
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [AW-1:0]         last_idx_q,  last_idx_d;
  logic [AW-1:0]         idx_q,       idx_d;
  logic                  dir_dn_q,    dir_dn_d;
  logic [IO_WIDTH-1:0]   io_out_q,    io_out_d;
  logic [IO_WIDTH-1:0]   io_oeb_q,    io_oeb_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  started_q,   started_d;
  logic [IO_WIDTH-1:0]   sync1_q,     sync1_d;
  logic [IO_WIDTH-1:0]   sync2_q,     sync2_d;
  logic                  cond_q,      cond_d;
  logic                  irq_q,       irq_d;

  logic                  tick;
  logic                  start_ok;
  logic [AW-1:0]         nxt_idx;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    prescale_d  = prescale_q;
    presc_cnt_d = presc_cnt_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    dir_dn_d    = dir_dn_q;
    io_out_d    = io_out_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    started_d   = started_q;
    nxt_idx     = idx_q;

    // Matcher: two-flop synchroniser, then compare; an all-zero mask disables it.
    sync1_d = bus.io_in;
    sync2_d = sync1_q;
    cond_d  = ((sync2_q & bus.match_mask) == (bus.match_val & bus.match_mask)) && (|bus.match_mask);
    irq_d   = cond_d & ~cond_q;

    tick     = (presc_cnt_q == prescale_q);
    start_ok = bus.start && !bus.stop && (state_q != ST_RUN);

    if (start_ok) begin
      state_d     = ST_RUN;
      mode_d      = bus.mode;
      prescale_d  = bus.prescale;
      last_idx_d  = bus.last_idx;
      presc_cnt_d = '0;
      idx_d       = '0;
      dir_dn_d    = 1'b0;
      busy_d      = 1'b1;
      started_d   = 1'b1;
      io_out_d    = (bus.mode == MODE_COUNT) ? '0 : mem_q[0];
    end else if (state_q == ST_RUN) begin
      if (bus.stop) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end else if (!tick) begin
        presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
      end else begin
        presc_cnt_d = '0;
        case (mode_q)
          MODE_ONESHOT: begin
            if (idx_q == last_idx_q) begin
              // Final word stays on the pins after completion.
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              nxt_idx  = idx_q + AW'(1);
              idx_d    = nxt_idx;
              io_out_d = mem_q[nxt_idx];
            end
          end
          MODE_LOOP: begin
            nxt_idx  = (idx_q == last_idx_q) ? '0 : idx_q + AW'(1);
            idx_d    = nxt_idx;
            io_out_d = mem_q[nxt_idx];
          end
          MODE_COUNT: begin
            io_out_d = io_out_q + IO_WIDTH'(1);
          end
          default: begin
            // Ping-pong: turn around at either end without repeating the end word.
            if (last_idx_q == '0) begin
              nxt_idx = '0;
            end else if (!dir_dn_q) begin
              if (idx_q == last_idx_q) begin
                nxt_idx  = idx_q - AW'(1);
                dir_dn_d = 1'b1;
              end else begin
                nxt_idx = idx_q + AW'(1);
              end
            end else begin
              if (idx_q == '0) begin
                nxt_idx  = AW'(1);
                dir_dn_d = 1'b0;
              end else begin
                nxt_idx = idx_q - AW'(1);
              end
            end
            idx_d    = nxt_idx;
            io_out_d = mem_q[nxt_idx];
          end
        endcase
      end
    end

    // Pads stay tri-stated until the sequencer has been started once.
    io_oeb_d = started_d ? ~bus.out_en : io_oeb_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ONESHOT;
      prescale_q  <= '0;
      presc_cnt_q <= '0;
      last_idx_q  <= '0;
      idx_q       <= '0;
      dir_dn_q    <= 1'b0;
      io_out_q    <= '0;
      io_oeb_q    <= '1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      started_q   <= 1'b0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      cond_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      presc_cnt_q <= presc_cnt_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      dir_dn_q    <= dir_dn_d;
      io_out_q    <= io_out_d;
      io_oeb_q    <= io_oeb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      started_q   <= started_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cond_q      <= cond_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.io_out    = io_out_q;
  assign bus.io_oeb    = io_oeb_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = idx_q;
  assign bus.match_irq = irq_q;
endmodule
